// File: rtl/issue_pkg.sv
// Shared issue-queue types: wakeup entry, opcode constants and latency classes.
package issue_pkg;

  localparam int WAKEUP_REG_W = 5;

  typedef struct packed {
    logic                    v;
    logic [WAKEUP_REG_W-1:0] dest;
  } wakeup_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    LAT_NONE,
    LAT_ALU,
    LAT_LOAD
  } lat_class_e;

endpackage

// File: rtl/wakeup_broadcaster_lat_decode.sv
// Opcode to execution-latency class; combinational, shared with the scheduler.
module lat_decode
  import issue_pkg::*;
#(
  parameter int OPC_W = 7
) (
  input  logic [OPC_W-1:0] opcode_i,
  output lat_class_e       lat_class_o
);

  always_comb begin
    lat_class_o = LAT_NONE;
    case (opcode_i)
      OPC_W'(OPC_OP),
      OPC_W'(OPC_OPIMM),
      OPC_W'(OPC_LUI),
      OPC_W'(OPC_AUIPC),
      OPC_W'(OPC_JAL),
      OPC_W'(OPC_JALR):  lat_class_o = LAT_ALU;
      OPC_W'(OPC_LOAD):  lat_class_o = LAT_LOAD;
      default:           lat_class_o = LAT_NONE;
    endcase
  end

endmodule

// File: rtl/wakeup_broadcaster.sv
// Fixed-latency delay line feeding the issue queue's single wakeup broadcast port.
module wakeup_broadcaster
  import issue_pkg::*;
#(
  parameter int LOAD_LAT = 3,
  parameter int OPC_W    = 7,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             issue_valid,
  input  logic [OPC_W-1:0] issue_opcode,
  input  logic [REG_W-1:0] issue_dest,
  output logic             issue_ready,
  output logic             wakeup_valid,
  output logic [REG_W-1:0] wakeup_dest,
  output logic             idle
);

  logic [LOAD_LAT-1:0] v_q;
  logic [LOAD_LAT-1:0] v_d;
  logic [REG_W-1:0]    dest_q [LOAD_LAT];
  logic [REG_W-1:0]    dest_d [LOAD_LAT];
  logic [LOAD_LAT-1:0] ins_sel;
  lat_class_e          lat_class;
  logic                accept;
  logic                ins_en;

  lat_decode #(
    .OPC_W(OPC_W)
  ) u_lat_decode (
    .opcode_i    (issue_opcode),
    .lat_class_o (lat_class)
  );

  // An older load sitting in stage 1 would land on stage 0 together with any
  // new ALU result, so grants are refused regardless of opcode.
  assign issue_ready = ~v_q[1];
  assign accept      = issue_valid & issue_ready & ~kill;
  assign ins_en      = accept & (lat_class != LAT_NONE) & (issue_dest != '0);

  for (genvar gi = 0; gi < LOAD_LAT; gi++) begin : g_stage
    localparam logic IS_ALU_SLOT  = (gi == 0);
    localparam logic IS_LOAD_SLOT = (gi == LOAD_LAT - 1);

    logic             sh_v;
    logic [REG_W-1:0] sh_dest;

    if (gi == LOAD_LAT - 1) begin : g_top
      assign sh_v    = 1'b0;
      assign sh_dest = '0;
    end else begin : g_mid
      assign sh_v    = v_q[gi+1];
      assign sh_dest = dest_q[gi+1];
    end

    assign ins_sel[gi] = ins_en & ((lat_class == LAT_ALU) ? IS_ALU_SLOT : IS_LOAD_SLOT);
    assign v_d[gi]     = ins_sel[gi] | (sh_v & ~kill);
    assign dest_d[gi]  = ins_sel[gi] ? issue_dest : sh_dest;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < LOAD_LAT; i++) begin
        dest_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      dest_q <= dest_d;
    end
  end

  assign wakeup_valid = v_q[0];
  assign wakeup_dest  = dest_q[0];
  assign idle         = ~|v_q;

endmodule
